// File: rtl/ysyx_23060096_wb_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060096_wb_pkg
// Shared definitions for the writeback arbiter slice.
//   WB_ADDR_WIDTH : default register index width (1 << WB_ADDR_WIDTH registers)
//   WB_DATA_WIDTH : default register data width
//   src_e         : writeback source identifier; also the bit position of the
//                   source inside the arbiter req/gnt vectors.
// ----------------------------------------------------------------------------
package ysyx_23060096_wb_pkg;

    localparam int WB_ADDR_WIDTH = 5;
    localparam int WB_DATA_WIDTH = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

endpackage

// File: rtl/ysyx_23060096_rr_arb2.sv
// ----------------------------------------------------------------------------
// ysyx_23060096_rr_arb2
// Two-requester round-robin arbiter with a combinational grant.
// Ports:
//   clk      in   clock
//   rstn     in   synchronous active-low reset
//   req[1:0] in   request vector, bit SRC_ALU / bit SRC_LSU
//   gnt[1:0] out  one-hot grant, or zero when nobody requests (comb)
// The arbiter owns the last-grant pointer. After reset the pointer names the
// LSU, so the ALU wins the first contested cycle.
// ----------------------------------------------------------------------------
module ysyx_23060096_rr_arb2
    import ysyx_23060096_wb_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    src_e last;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Contested: the source that did not win last time goes first.
            2'b11:   gnt = (last == SRC_LSU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last <= SRC_LSU;
        end else if (|req) begin
            last <= gnt[1] ? SRC_LSU : SRC_ALU;
        end
    end

endmodule

// File: rtl/ysyx_23060096_wb_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_23060096_wb_arbiter
// Shares the single register-file write port between the ALU and LSU
// writeback paths, and keeps a per-register busy scoreboard for decode.
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   issue_valid, issue_rd      decode issues an instruction writing issue_rd
//   chk_ra, chk_rb, chk_rd     operands of the instruction in decode
//   hazard                     comb: any checked register is busy
//   alu_valid/rd/data, ready   ALU writeback handshake
//   lsu_valid/rd/data, ready   LSU writeback handshake
//   rf_w_en/waddr/wdata        registered register-file write port
//   wb_err                     sticky: a writeback hit a non-busy register
// A grant in cycle N appears on the RF port in cycle N+1; the RF write and the
// busy-bit clear happen together at the end of N+1.
// ----------------------------------------------------------------------------
module ysyx_23060096_wb_arbiter
    import ysyx_23060096_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] chk_ra,
    input  logic [ADDR_WIDTH-1:0] chk_rb,
    input  logic [ADDR_WIDTH-1:0] chk_rd,
    output logic                  hazard,

    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,

    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,

    output logic                  rf_w_en,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  wb_err
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [1:0]            req;
    logic [1:0]            gnt;
    logic                  gnt_any;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  err_set;

    logic [NREG-1:0]       busy;
    logic [NREG-1:0]       busy_nxt;

    logic                  vld_p1;
    logic [ADDR_WIDTH-1:0] waddr_p1;
    logic [DATA_WIDTH-1:0] wdata_p1;
    logic                  err_p1;

    // ---- stage p0: arbitration and source select ----
    assign req = {lsu_valid, alu_valid};

    ysyx_23060096_rr_arb2 u_rr_arb2 (
        .clk  (clk),
        .rstn (rstn),
        .req  (req),
        .gnt  (gnt)
    );

    assign alu_ready = gnt[SRC_ALU];
    assign lsu_ready = gnt[SRC_LSU];
    assign gnt_any   = |gnt;

    always_comb begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
        if (gnt[SRC_LSU]) begin
            sel_rd   = lsu_rd;
            sel_data = lsu_data;
        end
    end

    // Writing a register nobody is waiting for means decode and the
    // execution units disagree; the write still goes through.
    assign err_set = gnt_any && (sel_rd != '0) && !busy[sel_rd];

    // Hazard looks at the busy bits as they are now; a write retiring this
    // cycle still reports a hazard until its clear has landed.
    assign hazard = busy[chk_ra] | busy[chk_rb] | busy[chk_rd];

    // Retire clears first, then a same-cycle issue re-sets the bit, so an
    // issue to a register that is retiring right now keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (vld_p1) begin
            busy_nxt[waddr_p1] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // ---- stage p1: registered RF write port, scoreboard, error flag ----
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
            busy     <= '0;
            err_p1   <= 1'b0;
        end else begin
            // x0 writes complete the handshake but never reach the RF.
            vld_p1 <= gnt_any && (sel_rd != '0);
            if (gnt_any) begin
                waddr_p1 <= sel_rd;
                wdata_p1 <= sel_data;
            end
            busy <= busy_nxt;
            if (err_set) begin
                err_p1 <= 1'b1;
            end
        end
    end

    assign rf_w_en  = vld_p1;
    assign rf_waddr = waddr_p1;
    assign rf_wdata = wdata_p1;
    assign wb_err   = err_p1;

    // Decode must not issue to a register that is still outstanding, unless
    // that register's write is retiring in this very cycle.
    issue_to_busy_a : assert property (@(posedge clk) disable iff (!rstn)
        !(issue_valid && busy[issue_rd] && !(vld_p1 && (waddr_p1 == issue_rd))));

endmodule

// File: tb/tb_ysyx_23060096_wb_arbiter.sv
// ----------------------------------------------------------------------------
// Bench for ysyx_23060096_wb_arbiter: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
// ----------------------------------------------------------------------------
module tb_ysyx_23060096_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic [AW-1:0] chk_ra, chk_rb, chk_rd;
    logic          hazard;
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          lsu_valid;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic          lsu_ready;
    logic          rf_w_en;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          wb_err;

    always #5 clk = ~clk;

    ysyx_23060096_wb_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .chk_ra      (chk_ra),
        .chk_rb      (chk_rb),
        .chk_rd      (chk_rd),
        .hazard      (hazard),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .rf_w_en     (rf_w_en),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .wb_err      (wb_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---- reference model state ----
    bit [31:0]     m_busy;
    bit            m_last_lsu;
    bit            m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            m_err;
    bit            g_alu, g_lsu;

    function automatic void m_reset();
        m_busy     = '0;
        m_last_lsu = 1'b1;
        m_en       = 1'b0;
        m_addr     = '0;
        m_data     = '0;
        m_err      = 1'b0;
    endfunction

    function automatic void m_grant(output bit ga, output bit gl);
        ga = 1'b0;
        gl = 1'b0;
        if (alu_valid && lsu_valid) begin
            if (m_last_lsu) ga = 1'b1;
            else            gl = 1'b1;
        end else if (alu_valid) begin
            ga = 1'b1;
        end else if (lsu_valid) begin
            gl = 1'b1;
        end
    endfunction

    function automatic bit m_hazard();
        return m_busy[chk_ra] | m_busy[chk_rb] | m_busy[chk_rd];
    endfunction

    function automatic void m_edge(input bit ga, input bit gl);
        bit [31:0]     nb;
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
        if (!rstn) begin
            m_reset();
        end else begin
            rd = gl ? lsu_rd : alu_rd;
            d  = gl ? lsu_data : alu_data;
            nb = m_busy;
            if (m_en) nb[m_addr] = 1'b0;
            if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
            if ((ga || gl) && rd != 0 && !m_busy[rd]) m_err = 1'b1;
            if (ga || gl) begin
                m_last_lsu = gl;
                m_en       = (rd != 0);
                m_addr     = rd;
                m_data     = d;
            end else begin
                m_en = 1'b0;
            end
            m_busy = nb;
        end
    endfunction

    // One clock cycle: comb outputs checked before the edge, registered
    // outputs checked just after it.
    task automatic step();
        bit ga, gl;
        #2;
        m_grant(ga, gl);
        check("alu_ready", alu_ready, ga);
        check("lsu_ready", lsu_ready, gl);
        check("hazard", hazard, m_hazard());
        @(posedge clk);
        m_edge(ga, gl);
        #1;
        check("rf_w_en", rf_w_en, m_en);
        if (m_en) begin
            check("rf_waddr", rf_waddr, m_addr);
            check("rf_wdata", rf_wdata, m_data);
        end
        check("wb_err", wb_err, m_err);
        g_alu = ga;
        g_lsu = gl;
    endtask

    function automatic logic [AW-1:0] pick_rd();
        logic [AW-1:0] r;
        r = AW'($urandom_range(0, 31));
        if ($urandom_range(0, 3) != 0) begin
            for (int k = 0; k < 8 && !m_busy[r]; k++) r = AW'($urandom_range(1, 31));
        end
        return r;
    endfunction

    task automatic rand_inputs();
        logic [AW-1:0] r;
        // A source only changes its request after a grant or while idle.
        if (!alu_valid || g_alu) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            alu_rd    = pick_rd();
            alu_data  = $urandom;
        end
        if (!lsu_valid || g_lsu) begin
            lsu_valid = ($urandom_range(0, 99) < 60);
            lsu_rd    = pick_rd();
            lsu_data  = $urandom;
        end
        r           = AW'($urandom_range(0, 31));
        issue_rd    = r;
        issue_valid = ($urandom_range(0, 99) < 40) && !(m_busy[r] && !(m_en && m_addr == r));
        chk_ra      = AW'($urandom_range(0, 31));
        chk_rb      = AW'($urandom_range(0, 31));
        chk_rd      = AW'($urandom_range(0, 31));
        rstn        = ($urandom_range(0, 299) != 0);
    endtask

    initial begin
        rstn        = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        chk_ra      = 5'd5;
        chk_rb      = 5'd7;
        chk_rd      = 5'd9;
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        lsu_valid   = 1'b0;
        lsu_rd      = '0;
        lsu_data    = '0;
        g_alu       = 1'b0;
        g_lsu       = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_w_en", rf_w_en, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_wb_err", wb_err, 0);
        check("rst_hazard", hazard, 0);
        rstn   = 1'b1;
        chk_ra = '0;
        chk_rb = '0;
        chk_rd = '0;

        // ALU alone: granted in N, visible on the RF port in N+1.
        issue_valid = 1'b1; issue_rd = 5'd5; step(); issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
        #2; check("t1_alu_ready", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        check("t1_w_en", rf_w_en, 1);
        check("t1_waddr", rf_waddr, 5);
        check("t1_wdata", rf_wdata, 32'h11);

        // LSU write to x0: handshake completes, nothing reaches the RF.
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hdead;
        #2; check("t5_lsu_ready", lsu_ready, 1);
        step();
        lsu_valid = 1'b0;
        check("t5_w_en", rf_w_en, 0);
        check("t5_wb_err", wb_err, 0);

        // Both sources contend for four cycles; grants alternate from ALU.
        issue_valid = 1'b1; issue_rd = 5'd1; step();
        issue_rd = 5'd2; step(); issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'ha1;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hb2;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("t2_alu_ready", alu_ready, (i % 2 == 0) ? 1 : 0);
            check("t2_lsu_ready", lsu_ready, (i % 2 == 1) ? 1 : 0);
            step();
            check("t2_waddr", rf_waddr, (i % 2 == 0) ? 1 : 2);
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;

        // Hazard on x7 persists through the retire cycle, clears after it.
        issue_valid = 1'b1; issue_rd = 5'd7; step(); issue_valid = 1'b0;
        chk_ra = 5'd7;
        #2; check("t3_haz_busy", hazard, 1);
        step();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
        step();
        lsu_valid = 1'b0;
        #2;
        check("t3_haz_retire", hazard, 1);
        check("t3_w_en", rf_w_en, 1);
        check("t3_waddr", rf_waddr, 7);
        step();
        #2; check("t3_haz_clear", hazard, 0);
        step();
        chk_ra = '0;

        // Re-issue x3 in the cycle its write retires: set beats clear.
        issue_valid = 1'b1; issue_rd = 5'd3; step(); issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33; step(); alu_valid = 1'b0;
        check("t4_w_en", rf_w_en, 1);
        issue_valid = 1'b1; issue_rd = 5'd3; step(); issue_valid = 1'b0;
        chk_rb = 5'd3;
        #2; check("t4_haz", hazard, 1);
        step();

        // Reset in the grant cycle drops the write and clears the scoreboard.
        issue_valid = 1'b1; issue_rd = 5'd9; step(); issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        chk_ra = 5'd9; chk_rb = 5'd3; chk_rd = 5'd1;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        alu_valid = 1'b0;
        check("t6_w_en", rf_w_en, 0);
        check("t6_err_clr", wb_err, 0);
        #2; check("t6_haz", hazard, 0);
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        step();
        alu_valid = 1'b0;
        check("t6_w_en_x4", rf_w_en, 1);
        check("t6_wb_err", wb_err, 1);

        // Random traffic.
        repeat (3000) begin
            rand_inputs();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
